// File: rtl/hash_round_unwind.sv
// rtl/hash_round_unwind.sv - undoes hash main rounds one S-box value at a time
// Digest is loaded on start, unwound last-round-first, and the initial state is held until accepted.
module hash_round_unwind #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0][3:0]  digest,
  input  logic [CNT_W-1:0] n_rounds,
  input  logic             s_valid,
  input  logic [3:0]       s_value,
  output logic             s_ready,
  input  logic             abort,
  output logic             busy,
  output logic [CNT_W-1:0] rounds_left,
  output logic             out_valid,
  output logic [7:0][3:0]  h_init,
  input  logic             out_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [7:0][3:0]  h_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0][3:0]  h_d;

  function automatic logic [3:0] rotr4(input logic [3:0] x, input logic [1:0] k);
    logic [7:0] t;
    t = {x, x} >> k;
    return t[3:0];
  endfunction

  // Each lane came from its right-hand neighbour after xor with s and a left rotate.
  always_comb begin
    h_d    = '0;
    h_d[1] = h_q[0] ^ s_value;
    h_d[2] = h_q[1] ^ s_value;
    h_d[3] = rotr4(h_q[2], 2'd1) ^ s_value;
    h_d[4] = rotr4(h_q[3], 2'd1) ^ s_value;
    h_d[5] = rotr4(h_q[4], 2'd2) ^ s_value;
    h_d[6] = rotr4(h_q[5], 2'd2) ^ s_value;
    h_d[7] = rotr4(h_q[6], 2'd3) ^ s_value;
    h_d[0] = rotr4(h_q[7], 2'd3) ^ s_value;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      h_q     <= '0;
      cnt_q   <= '0;
    end else if (abort) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          h_q     <= digest;
          cnt_q   <= n_rounds;
          state_q <= (n_rounds == '0) ? DONE : RUN;
        end
        RUN: if (s_valid) begin
          h_q   <= h_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= DONE;
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready     = (state_q == RUN);
  assign busy        = (state_q != IDLE);
  assign out_valid   = (state_q == DONE);
  assign h_init      = (state_q == DONE) ? h_q : '0;
  assign rounds_left = cnt_q;

endmodule

// File: tb/tb_hash_round_unwind.sv
// tb/tb_hash_round_unwind.sv - self-checking bench for hash_round_unwind
module tb_hash_round_unwind;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [7:0][3:0] digest;
  logic [7:0]      n_rounds;
  logic            s_valid;
  logic [3:0]      s_value;
  logic            s_ready;
  logic            abort;
  logic            busy;
  logic [7:0]      rounds_left;
  logic            out_valid;
  logic [7:0][3:0] h_init;
  logic            out_ready;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  hash_round_unwind #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .digest(digest), .n_rounds(n_rounds),
    .s_valid(s_valid), .s_value(s_value), .s_ready(s_ready), .abort(abort),
    .busy(busy), .rounds_left(rounds_left), .out_valid(out_valid),
    .h_init(h_init), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] rotl(input logic [3:0] x, input int k);
    logic [7:0] t;
    t = {x, x} << k;
    return t[7:4];
  endfunction

  // Forward main round: out[i] = rotl_(i/2)(h[(i+1)%8] ^ s)
  function automatic logic [31:0] fwd(input logic [31:0] hv, input logic [3:0] s);
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < 8; i++)
      o[4*i +: 4] = rotl(hv[4*((i+1)%8) +: 4] ^ s, i / 2);
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ovalid"}, 32'(out_valid), 32'd0);
    chk({tag, "_sready"}, 32'(s_ready), 32'd0);
    chk({tag, "_hinit"}, h_init, 32'd0);
  endtask

  task automatic run_chain(input int n, input bit gaps, input string tag);
    logic [31:0] h0, h;
    logic [3:0]  sl[$];
    int left, cyc;
    h0 = $urandom;
    h = h0;
    sl.delete();
    for (int r = 0; r < n; r++) begin
      sl.push_back(4'($urandom));
      h = fwd(h, sl[r]);
    end
    digest = h; n_rounds = 8'(n); start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_rl_start"}, 32'(rounds_left), 32'(n));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    left = n;
    cyc = 0;
    while (left > 0 && cyc < 2000) begin
      chk({tag, "_sready"}, 32'(s_ready), 32'd1);
      s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_value = s_valid ? sl[left-1] : 4'($urandom);
      step();
      cyc++;
      if (s_valid) left--;
      chk({tag, "_rl"}, 32'(rounds_left), 32'(left));
    end
    s_valid = 1'b0;
    if (left > 0) chk({tag, "_timeout"}, 32'(left), 32'd0);
    chk({tag, "_ovalid"}, 32'(out_valid), 32'd1);
    chk({tag, "_hinit"}, h_init, h0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_idle({tag, "_after"});
  endtask

  initial begin
    logic [31:0] h0, h;
    logic [3:0]  sl[$];
    rst = 1'b1; start = 1'b0; digest = '0; n_rounds = '0; s_valid = 1'b0;
    s_value = '0; abort = 1'b0; out_ready = 1'b0;
    #12;
    check_idle("reset");
    chk("reset_rl", 32'(rounds_left), 32'd0);
    rst = 1'b0;
    step();

    // Directed single round
    digest = 32'h5E3FD38B; n_rounds = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_sready", 32'(s_ready), 32'd1);
    chk("t1_rl", 32'(rounds_left), 32'd1);
    s_valid = 1'b1; s_value = 4'hA;
    step();
    s_valid = 1'b0;
    chk("t1_ovalid", 32'(out_valid), 32'd1);
    chk("t1_hinit", h_init, 32'h76543210);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_idle("t1_after");

    // Zero rounds, then hold in DONE with start and s_valid ignored
    digest = 32'hDEADBEEF; n_rounds = 8'd0; start = 1'b1;
    step();
    chk("t2_ovalid", 32'(out_valid), 32'd1);
    chk("t2_hinit", h_init, 32'hDEADBEEF);
    chk("t2_rl", 32'(rounds_left), 32'd0);
    digest = 32'h12345678; n_rounds = 8'd3; s_valid = 1'b1; s_value = 4'h5;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_ovalid", 32'(out_valid), 32'd1);
      chk("t4_hinit", h_init, 32'hDEADBEEF);
      chk("t4_sready", 32'(s_ready), 32'd0);
    end
    start = 1'b0; s_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_idle("t4_after");

    // Random chains, with and without gaps, including the maximum count
    run_chain(8, 1'b1, "t3a");
    run_chain(8, 1'b1, "t3b");
    run_chain(5, 1'b0, "t3c");
    run_chain(255, 1'b0, "t3max");

    // Reset mid-operation
    digest = $urandom; n_rounds = 8'd8; start = 1'b1;
    step();
    start = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_value = 4'($urandom);
      step();
    end
    chk("t5_rl_pre", 32'(rounds_left), 32'd5);
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_idle("t5_rst");
    chk("t5_rl", 32'(rounds_left), 32'd0);
    step();
    rst = 1'b0;
    run_chain(4, 1'b1, "t5_new");

    // Abort coinciding with the last handshake
    h0 = $urandom; h = h0; sl.delete();
    for (int r = 0; r < 2; r++) begin
      sl.push_back(4'($urandom));
      h = fwd(h, sl[r]);
    end
    digest = h; n_rounds = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    s_valid = 1'b1; s_value = sl[1];
    step();
    s_value = sl[0]; abort = 1'b1;
    step();
    abort = 1'b0; s_valid = 1'b1; s_value = 4'h3;
    check_idle("t6_abort");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_noout", 32'(out_valid), 32'd0);
    end
    s_valid = 1'b0;
    run_chain(3, 1'b1, "t6_new");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
